// File: rtl/ps2_key_serializer.sv
// Turns hps_io keyboard event words into a device-side PS/2 set-2 serial
// stream. Each event expands to 1-3 scancode bytes (E0 / F0 prefixes). The
// bytes are buffered in a small FIFO and clocked out as 11-bit frames. The
// block backs off whenever the host holds the clock line low.
module ps2_key_serializer #(
    parameter int CLK_HZ     = 28636000,
    parameter int PS2_HZ     = 12000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_out,
    output logic        ps2_data_out,
    output logic        busy,
    output logic        overflow
);

    localparam int T  = CLK_HZ / PS2_HZ;
    localparam int H  = T / 2;
    localparam int PW = $clog2(T);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [PW-1:0] PH_T_END = PW'(T - 1);
    localparam logic [PW-1:0] PH_H_END = PW'(H - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_ABORT,
        ST_GAP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Line synchronizers. The data line has no consumer yet. It is kept
    // synchronized so a later status path can tap it directly.
    // ------------------------------------------------------------------
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_s;
    logic       data_s_unused;

    // Two-flop synchronizers. They idle high, which is the released-line level.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_data_in};
        end
    end

    assign clk_s         = clk_sync[1];
    assign data_s_unused = dat_sync[1];

    // ------------------------------------------------------------------
    // Event detect and the 1-deep pending slot
    // ------------------------------------------------------------------
    logic       tog_q;
    logic       init_q;
    logic       key_evt;
    logic       pend_vld;
    logic       pend_pressed;
    logic       pend_ext;
    logic [7:0] pend_code;
    logic       seq_start;

    // The first cycle after reset only captures the toggle level. This stops
    // a stale strobe from looking like a new key event.
    assign key_evt = !init_q && (ps2_key[10] != tog_q);

    // Track the toggle level. Latch a new event, or overwrite an unconsumed one.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q        <= 1'b0;
            init_q       <= 1'b1;
            pend_vld     <= 1'b0;
            pend_pressed <= 1'b0;
            pend_ext     <= 1'b0;
            pend_code    <= 8'h00;
        end else begin
            init_q <= 1'b0;
            tog_q  <= ps2_key[10];
            if (seq_start)
                pend_vld <= 1'b0;
            if (key_evt) begin
                pend_vld     <= 1'b1;
                pend_pressed <= ps2_key[9];
                pend_ext     <= ps2_key[8];
                pend_code    <= ps2_key[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Push sequencer: E0? F0? code, one byte per cycle
    // ------------------------------------------------------------------
    logic          seq_act;
    logic          seq_e0;
    logic          seq_f0;
    logic [7:0]    seq_code;
    logic          cur_e0;
    logic          cur_f0;
    logic [7:0]    cur_code;
    logic [1:0]    need;
    logic [CW-1:0] cnt;
    logic [CW-1:0] free_cnt;
    logic          fits;
    logic          wr_en;
    logic [7:0]    wr_data;

    // When idle, the sequencer reads the pending slot directly. The first
    // byte can then go out in the same cycle the event is accepted.
    always_comb begin
        cur_e0    = seq_act ? seq_e0   : pend_ext;
        cur_f0    = seq_act ? seq_f0   : !pend_pressed;
        cur_code  = seq_act ? seq_code : pend_code;
        need      = 2'd1 + {1'b0, cur_e0} + {1'b0, cur_f0};
        free_cnt  = CW'(FIFO_DEPTH) - cnt;
        fits      = free_cnt >= CW'(need);
        seq_start = !seq_act && pend_vld;
        wr_en     = seq_act || (seq_start && fits);
        wr_data   = cur_e0 ? 8'hE0 : (cur_f0 ? 8'hF0 : cur_code);
    end

    // Step through the remaining prefixes. Drop any event that does not fit whole.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            seq_act  <= 1'b0;
            seq_e0   <= 1'b0;
            seq_f0   <= 1'b0;
            seq_code <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                seq_act  <= cur_e0 || cur_f0;
                seq_e0   <= 1'b0;
                seq_f0   <= cur_e0 && cur_f0;
                seq_code <= cur_code;
            end
            if (seq_start && !fits)
                overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    head;
    logic [10:0]   frame;

    // Storage array. A write never hits the head while a frame is using it.
    always_ff @(posedge clk_sys) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy. A push and a pop in the same cycle are both honoured.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign fifo_empty = (cnt == '0);
    assign head       = mem[rd_ptr];
    // Frame bit order: stop, odd parity, data MSB..LSB, start.
    assign frame      = {1'b1, ~^head, head, 1'b0};

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    tx_state_t     state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [3:0]    idx_q, idx_d;
    logic          lap_q, lap_d;
    logic          clk_drv;
    logic          dat_drv;

    // State register. The phase counter is too narrow for 2T, so GAP runs
    // two T-long laps.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            idx_q   <= '0;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            lap_q   <= lap_d;
        end
    end

    // Next state and line drive. Every state change reloads the phase counter.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q + 1'b1;
        idx_d   = idx_q;
        lap_d   = lap_q;
        pop     = 1'b0;
        clk_drv = 1'b1;
        dat_drv = 1'b1;
        case (state_q)
            ST_IDLE: begin
                // In IDLE the phase counter counts consecutive clock-high
                // cycles and saturates at T-1.
                if (!clk_s) begin
                    ph_d = '0;
                end else if (ph_q == PH_T_END) begin
                    ph_d = ph_q;
                    if (!fifo_empty) begin
                        state_d = ST_BIT_HI;
                        ph_d    = '0;
                        idx_d   = '0;
                    end
                end
            end
            ST_BIT_HI: begin
                // Let go of data in the same cycle the host inhibit is seen.
                dat_drv = clk_s ? frame[idx_q] : 1'b1;
                if (!clk_s) begin
                    state_d = ST_ABORT;
                    ph_d    = '0;
                end else if (ph_q == PH_H_END) begin
                    state_d = ST_BIT_LO;
                    ph_d    = '0;
                end
            end
            ST_BIT_LO: begin
                clk_drv = 1'b0;
                dat_drv = frame[idx_q];
                if (ph_q == PH_H_END) begin
                    ph_d = '0;
                    if (idx_q == 4'd10) begin
                        pop     = 1'b1;
                        state_d = ST_GAP;
                        lap_d   = 1'b0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_BIT_HI;
                    end
                end
            end
            ST_ABORT: begin
                // The head byte stays queued. It is resent from the start bit.
                state_d = ST_GAP;
                ph_d    = '0;
                lap_d   = 1'b0;
            end
            ST_GAP: begin
                if (ph_q == PH_T_END) begin
                    ph_d = '0;
                    if (lap_q) begin
                        state_d = ST_IDLE;
                        lap_d   = 1'b0;
                    end else begin
                        lap_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ph_d    = '0;
            end
        endcase
    end

    assign ps2_clk_out  = clk_drv;
    assign ps2_data_out = dat_drv;
    assign busy         = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Directed bench for ps2_key_serializer with T = 12 cycles and a 4-deep FIFO.
// A line monitor rebuilds frames from the falling edges of ps2_clk_out.
module tb_ps2_key_serializer;

    localparam int T = 12;
    localparam int H = 6;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] ps2_key = 11'h000;
    logic        host_clk = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic        ps2_clk_out;
    logic        ps2_data_out;
    logic        busy;
    logic        overflow;

    ps2_key_serializer #(
        .CLK_HZ    (1200),
        .PS2_HZ    (100),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .ps2_clk_in  (host_clk),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_out (ps2_clk_out),
        .ps2_data_out(ps2_data_out),
        .busy        (busy),
        .overflow    (overflow)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- line monitor ----------------
    int          mon_run = 0;
    int          mon_last_run = 0;
    int          mon_bitcnt = 0;
    int          mon_chi = 0;
    int          mon_last_fall = 0;
    int          mon_stop_cyc = 0;
    int          mon_drv = 0;
    bit          mon_spacing_bad = 1'b0;
    logic        mon_prev_clk = 1'b1;
    logic [10:0] mon_bits = '0;
    logic [10:0] frame_q[$];
    int          gap_q[$];

    initial begin : monitor
        forever begin
            @(negedge clk_sys);
            if (ps2_clk_out && ps2_data_out) begin
                mon_run++;
            end else begin
                if (mon_run > 0) mon_last_run = mon_run;
                mon_run = 0;
                mon_drv++;
            end
            if (ps2_clk_out) mon_chi++; else mon_chi = 0;
            if (mon_chi > T) mon_bitcnt = 0;
            if (mon_prev_clk && !ps2_clk_out) begin
                if (mon_bitcnt == 0) gap_q.push_back(mon_last_run);
                else if (cyc - mon_last_fall != T) mon_spacing_bad = 1'b1;
                mon_bits[mon_bitcnt] = ps2_data_out;
                mon_bitcnt++;
                mon_last_fall = cyc;
                if (mon_bitcnt == 11) begin
                    frame_q.push_back(mon_bits);
                    mon_bitcnt   = 0;
                    mon_stop_cyc = cyc;
                end
            end
            mon_prev_clk = ps2_clk_out;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        @(posedge clk_sys);
        #1;
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic wait_frames(input int n, input string name);
        int k;
        k = 0;
        while (frame_q.size() < n && k < 3000) begin
            @(negedge clk_sys);
            k++;
        end
        check({name, "_frames_arrive"}, frame_q.size() >= n, 1);
    endtask

    task automatic wait_idle(input string name, output int at);
        int k;
        k = 0;
        @(negedge clk_sys);
        while (busy && k < 3000) begin
            @(negedge clk_sys);
            k++;
        end
        at = cyc;
        check({name, "_busy_clears"}, busy, 0);
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic        pressed;
        logic        ext;
        logic [7:0]  code;
        int          nb;
        logic [10:0] fr0;
        logic [10:0] fr1;
        logic [10:0] fr2;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          t_idle;
        int          got;
        int          k;
        logic [10:0] exp;

        vecs[0] = '{1'b1, 1'b0, 8'h1C, 1, 11'h438, 11'h000, 11'h000};
        vecs[1] = '{1'b0, 1'b1, 8'h75, 3, 11'h5C0, 11'h7E0, 11'h4EA};
        vecs[2] = '{1'b1, 1'b1, 8'h6B, 2, 11'h5C0, 11'h4D6, 11'h000};
        vecs[3] = '{1'b0, 1'b0, 8'h1C, 2, 11'h7E0, 11'h438, 11'h000};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1, 11'h600, 11'h000, 11'h000};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 1, 11'h7FE, 11'h000, 11'h000};

        // Reset state
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("rst_clk_out", ps2_clk_out, 1);
        check("rst_data_out", ps2_data_out, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        check("post_rst_no_frame", frame_q.size(), 0);

        // Table-driven single events
        for (int v = 0; v < 6; v++) begin
            frame_q.delete();
            gap_q.delete();
            mon_spacing_bad = 1'b0;
            send(vecs[v].pressed, vecs[v].ext, vecs[v].code);
            wait_frames(vecs[v].nb, $sformatf("v%0d", v));
            for (int j = 0; j < vecs[v].nb; j++) begin
                exp = (j == 0) ? vecs[v].fr0 : ((j == 1) ? vecs[v].fr1 : vecs[v].fr2);
                check($sformatf("v%0d_frame%0d", v, j),
                      (j < frame_q.size()) ? 32'(frame_q[j]) : 32'hDEAD, 32'(exp));
                if (j > 0)
                    check($sformatf("v%0d_gap%0d_ge24", v, j),
                          (j < gap_q.size()) ? 32'(gap_q[j] >= 24) : 32'd0, 1);
            end
            wait_idle($sformatf("v%0d", v), t_idle);
            if (v == 0)
                check("v0_busy_fall_delay", t_idle - mon_stop_cyc, H + 2 * T);
            check($sformatf("v%0d_frame_count", v), frame_q.size(), vecs[v].nb);
            check($sformatf("v%0d_bit_spacing", v), mon_spacing_bad, 0);
            check($sformatf("v%0d_overflow", v), overflow, 0);
        end

        // Overflow: host inhibits the line, 4 bytes fit, the 5th is dropped
        frame_q.delete();
        @(posedge clk_sys);
        #1 host_clk = 1'b0;
        repeat (5) @(negedge clk_sys);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0, 8'(8'h10 + i));
            repeat (4) @(negedge clk_sys);
            if (i == 3) check("ovf_exactly_full_no_flag", overflow, 0);
        end
        check("ovf_flag_set", overflow, 1);
        check("ovf_busy", busy, 1);
        check("ovf_no_tx_while_inhibited", frame_q.size(), 0);
        @(posedge clk_sys);
        #1 host_clk = 1'b1;
        wait_frames(4, "ovf");
        for (int j = 0; j < 4; j++)
            check($sformatf("ovf_frame%0d", j),
                  (j < frame_q.size()) ? 32'(frame_q[j]) : 32'hDEAD,
                  32'(frame_of(8'(8'h10 + j))));
        wait_idle("ovf", t_idle);
        check("ovf_frame_count", frame_q.size(), 4);
        check("ovf_sticky", overflow, 1);

        // Abort during BIT_HI of idx 5, then retransmit the whole byte
        frame_q.delete();
        send(1'b1, 1'b0, 8'h2B);
        k = 0;
        while (mon_bitcnt != 5 && k < 2000) begin
            @(negedge clk_sys);
            k++;
        end
        check("abort_reach_idx5", mon_bitcnt, 5);
        k = 0;
        while (!ps2_clk_out && k < 20) begin
            @(negedge clk_sys);
            k++;
        end
        check("abort_idx5_data_driven", ps2_data_out, 0);
        @(posedge clk_sys);
        #1 host_clk = 1'b0;
        got = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_sys);
            if (got == 0 && ps2_clk_out && ps2_data_out) got = i;
        end
        check("abort_release_within_3", got != 0, 1);
        mon_drv = 0;
        repeat (40) @(negedge clk_sys);
        check("abort_lines_stay_released", mon_drv, 0);
        check("abort_no_frame", frame_q.size(), 0);
        check("abort_busy_held", busy, 1);
        @(posedge clk_sys);
        #1 host_clk = 1'b1;
        wait_frames(1, "abort");
        check("abort_retx_frame", frame_q.size() > 0 ? 32'(frame_q[0]) : 32'hDEAD, 32'h656);
        wait_idle("abort", t_idle);
        check("abort_frame_count", frame_q.size(), 1);

        // Reset mid-frame while the toggle bit is 1
        frame_q.delete();
        send(1'b1, 1'b0, 8'h29);
        k = 0;
        while (mon_bitcnt != 3 && k < 2000) begin
            @(negedge clk_sys);
            k++;
        end
        check("rstmid_reach_bit3", mon_bitcnt, 3);
        @(posedge clk_sys);
        #3 reset_n = 1'b0;
        #1;
        check("rstmid_clk_out_async", ps2_clk_out, 1);
        check("rstmid_data_out_async", ps2_data_out, 1);
        check("rstmid_busy_async", busy, 0);
        check("rstmid_overflow_cleared", overflow, 0);
        repeat (3) @(posedge clk_sys);
        #3 reset_n = 1'b1;
        mon_drv = 0;
        repeat (100) @(negedge clk_sys);
        check("rstmid_no_spurious_drive", mon_drv, 0);
        check("rstmid_no_spurious_frame", frame_q.size(), 0);
        check("rstmid_idle_busy", busy, 0);
        send(1'b1, 1'b0, 8'h29);
        wait_frames(1, "rstmid");
        check("rstmid_frame", frame_q.size() > 0 ? 32'(frame_q[0]) : 32'hDEAD, 32'h452);
        wait_idle("rstmid", t_idle);
        check("rstmid_frame_count", frame_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
